gate_bist2: RTL and testbench
=============================

Name: gate_bist2

Overview:
- Hardware self-test sequencer for any 2-input primitive (gate_or, gate_and, gate_xor, ...).
- Drives the four input combinations into the DUT, waits a programmable settle time, and samples the DUT output.
- Compares each sample against a truth-table parameter, then reports pass/fail per vector and overall.
- Sits beside a primitive instance in on-chip or FPGA bring-up builds, replacing the open-loop simulation stimulus with a clocked responder/checker.

Parameters:
- TRUTH, 4'b1110, expected DUT output indexed by {b,a}; bit0 is a=0,b=0. The default is the OR truth table.
- SETTLE, 2, clock cycles between applying a vector and sampling s. Legal range 1..15.
- CNT_W, 4, width of the settle counter. Must satisfy 2**CNT_W > SETTLE.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to run the test; sampled in IDLE and DONE only.
- a  out  1  DUT input a.
- b  out  1  DUT input b.
- s  in  1  DUT output under test.
- busy  out  1  high from the cycle after start is accepted until done rises.
- done  out  1  high in DONE; stays high until the next start or reset.
- pass  out  1  valid while done is high; 1 iff all four vectors matched.
- fail_vec  out  4  bit i = 1 if vector i ({b,a}=i) mismatched.
- fail_count  out  3  number of mismatching vectors, 0..4.

Behaviour:
- Reset (rst_n=0, async): state=IDLE, a=0, b=0, busy=0, done=0, pass=0, fail_vec=0, fail_count=0, settle counter=0.
- FSM states: IDLE, APPLY, SETTLE, SAMPLE, DONE.
- IDLE, start=1 -> APPLY:
  - vector index v=0, fail_vec cleared, fail_count cleared, busy=1.
- APPLY (1 cycle) -> SETTLE:
  - {b,a} registered to v.
  - settle counter loaded with SETTLE-1.
- SETTLE: counter decrements each cycle; -> SAMPLE when counter==0. SETTLE=1 therefore spends exactly one cycle here.
- SAMPLE (1 cycle):
  - On mismatch (s != TRUTH[v]): fail_vec[v]=1 and fail_count+=1.
  - If v==3 -> DONE; else v+=1 -> APPLY.
- Vector order: v=0 (a0,b0), 1 (a1,b0), 2 (a0,b1), 3 (a1,b1). a=v[0], b=v[1].
- DONE:
  - busy=0, done=1, pass=(fail_count==0).
  - a and b hold the last vector (1,1).
- DONE, start=1: clears done, pass and results, and enters APPLY with v=0, the same as from IDLE.
- start while busy: ignored; no restart and no effect on results.
- Latency from start accepted to done rising: 4*(SETTLE+2) cycles. With default SETTLE=2 this is 16 cycles.
- Reset mid-run: immediate return to reset values; a partial result is never reported.
- fail_count saturates naturally at 4; the 3-bit width means it never wraps.
- s is sampled only in SAMPLE; glitches on s in other states are ignored.

Decomposition:
- Package gate_bist_pkg:
  - state enum (IDLE, APPLY, SETTLE, SAMPLE, DONE).
  - truth constants TT_AND=4'b1000, TT_OR=4'b1110, TT_XOR=4'b0110, TT_NAND=4'b0111, TT_NOR=4'b0001, TT_XNOR=4'b1001.
- One sub-module is natural: gate_bist_timer, a loadable down-counter with a zero flag, parameterised by CNT_W.

Test Plan:
- Good OR with default params: gate_or as DUT, pulse start -> done rises 16 cycles later, pass=1, fail_vec=0000, fail_count=0; a,b sequence 00,10,01,11 observed.
- Wrong gate: gate_and as DUT with TRUTH=TT_OR -> vectors 1 and 2 mismatch; fail_vec=0110, fail_count=2, pass=0.
- Stuck-at-1 on s with TRUTH=TT_OR -> fail_vec=0001, fail_count=1, pass=0. Stuck-at-0 -> fail_vec=1110, fail_count=3.
- SETTLE=1 and SETTLE=5 runs -> done after 12 and 28 cycles respectively; s is sampled exactly SETTLE+1 cycles after a,b change.
- start pulsed again at cycle 5 of a run -> ignored; result identical to an uninterrupted run. start in DONE -> results clear and a new 16-cycle run begins.
- rst_n asserted during SETTLE of vector 2 -> all outputs return to reset values within the same cycle (async). After release the FSM stays in IDLE until start.

Source files
------------

// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the 2-input gate self-test sequencer.
package gate_bist_pkg;

    // Sequencer states; the encoding is also visible on the debug state port.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Truth tables indexed by {b,a}; bit0 is a=0,b=0.
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_XNOR = 4'b1001;

endpackage

// File: rtl/gate_bist_timer.sv
// Loadable down-counter with a zero flag, used to time the settle window.
module gate_bist_timer #(
    parameter int CNT_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    // Load has priority; decrement stops at zero so the count never wraps.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/gate_bist2.sv
// Self-test sequencer for a 2-input primitive: walks {b,a} through 00,01,10,11,
// waits SETTLE cycles per vector, samples s and compares it with TRUTH.
//
// Handshake: i_start is a single-cycle request honoured only in IDLE or DONE;
// while o_busy is high it is ignored. o_done stays high until the next
// accepted start or reset, and o_pass/o_fail_vec/o_fail_count are only
// meaningful while o_done is high.
module gate_bist2
    import gate_bist_pkg::*;
#(
    parameter logic [3:0] TRUTH  = TT_OR,
    parameter int         SETTLE = 2,
    parameter int         CNT_W  = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    output logic       o_a,
    output logic       o_b,
    input  logic       i_s,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_pass,
    output logic [3:0] o_fail_vec,
    output logic [2:0] o_fail_count,
    output logic [2:0] o_state
);

    // Counter reload value: SETTLE-1 means the SETTLE state lasts SETTLE cycles.
    localparam logic [CNT_W-1:0] LP_SETTLE_M1 = CNT_W'(SETTLE - 1);

    state_t     r_state;
    logic [1:0] r_vec;
    logic       r_a;
    logic       r_b;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic [3:0] r_fail_vec;
    logic [2:0] r_fail_count;

    logic       w_timer_load;
    logic       w_timer_dec;
    logic       w_timer_zero;
    logic       w_mismatch;
    logic [2:0] w_fail_count_next;

    assign w_timer_load      = (r_state == ST_APPLY);
    assign w_timer_dec       = (r_state == ST_SETTLE);
    assign w_mismatch        = (i_s != TRUTH[r_vec]);
    assign w_fail_count_next = r_fail_count + {2'b00, w_mismatch};

    gate_bist_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_timer_load),
        .i_load_val (LP_SETTLE_M1),
        .i_dec      (w_timer_dec),
        .o_zero     (w_timer_zero)
    );

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_vec        <= 2'd0;
            r_a          <= 1'b0;
            r_b          <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_fail_vec   <= 4'd0;
            r_fail_count <= 3'd0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        r_state      <= ST_APPLY;
                        r_vec        <= 2'd0;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_pass       <= 1'b0;
                        r_fail_vec   <= 4'd0;
                        r_fail_count <= 3'd0;
                    end
                end
                ST_APPLY: begin
                    r_a     <= r_vec[0];
                    r_b     <= r_vec[1];
                    r_state <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (w_timer_zero) begin
                        r_state <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    if (w_mismatch) begin
                        r_fail_vec[r_vec] <= 1'b1;
                    end
                    r_fail_count <= w_fail_count_next;
                    if (r_vec == 2'd3) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_fail_count_next == 3'd0);
                    end else begin
                        r_vec   <= r_vec + 2'd1;
                        r_state <= ST_APPLY;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_a          = r_a;
    assign o_b          = r_b;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_pass       = r_pass;
    assign o_fail_vec   = r_fail_vec;
    assign o_fail_count = r_fail_count;
    assign o_state      = r_state;

endmodule

// File: tb/tb_gate_bist2.sv
// Bench for gate_bist2: three sequencers (SETTLE = 2, 1, 5) run side by side
// against a modelled gate whose truth table the bench chooses per run.
module tb_gate_bist2;
    import gate_bist_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] gate_tt;
    bit         strict_mode;

    logic       a_w    [3];
    logic       b_w    [3];
    logic       s_w    [3];
    logic       busy_w [3];
    logic       done_w [3];
    logic       pass_w [3];
    logic [3:0] fv_w   [3];
    logic [2:0] fc_w   [3];
    logic [2:0] st_w   [3];

    int n_vec  = 0;
    int n_miss = 0;

    // clock / reset block
    always #5 clk = ~clk;

    function automatic int settle_of(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 1 : 5);
    endfunction

    // DUT instances plus a modelled gate per instance. In strict mode the gate
    // answers correctly only in the single cycle that precedes the intended
    // sampling edge (SETTLE+1 cycles after the vector is applied) and answers
    // inverted at every other time, so any sampling-time error shows up.
    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int S = (k == 0) ? 2 : ((k == 1) ? 1 : 5);
        logic [3:0] age       = 4'd0;
        logic [1:0] prev_ab   = 2'b00;
        logic       prev_busy = 1'b0;

        gate_bist2 #(
            .TRUTH  (TT_OR),
            .SETTLE (S),
            .CNT_W  (4)
        ) u_dut (
            .i_clk        (clk),
            .i_rst_n      (rst_n),
            .i_start      (start),
            .o_a          (a_w[k]),
            .o_b          (b_w[k]),
            .i_s          (s_w[k]),
            .o_busy       (busy_w[k]),
            .o_done       (done_w[k]),
            .o_pass       (pass_w[k]),
            .o_fail_vec   (fv_w[k]),
            .o_fail_count (fc_w[k]),
            .o_state      (st_w[k])
        );

        always @(negedge clk) begin
            if (busy_w[k] && !prev_busy) age = 4'd0;
            else if ({b_w[k], a_w[k]} != prev_ab) age = 4'd1;
            else if (age != 4'd15) age = age + 4'd1;
            prev_ab   = {b_w[k], a_w[k]};
            prev_busy = busy_w[k];
        end

        assign s_w[k] = gate_tt[{b_w[k], a_w[k]}] ^ (strict_mode && (age != 4'(S + 1)));
    end

    // scoreboard comparison
    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string when);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s_a%0d", when, k), 8'(a_w[k]), 8'd0);
            check($sformatf("%s_b%0d", when, k), 8'(b_w[k]), 8'd0);
            check($sformatf("%s_busy%0d", when, k), 8'(busy_w[k]), 8'd0);
            check($sformatf("%s_done%0d", when, k), 8'(done_w[k]), 8'd0);
            check($sformatf("%s_pass%0d", when, k), 8'(pass_w[k]), 8'd0);
            check($sformatf("%s_fv%0d", when, k), 8'(fv_w[k]), 8'd0);
            check($sformatf("%s_fc%0d", when, k), 8'(fc_w[k]), 8'd0);
            check($sformatf("%s_state%0d", when, k), 8'(st_w[k]), 8'(ST_IDLE));
        end
    endtask

    // driver: one full self-test with the gate modelled by tt
    task automatic run_test(input logic [3:0] tt, input bit strict, input bit repulse);
        logic [3:0] truth;
        logic [3:0] exp_fv;
        int         exp_fc;
        int         lat [3];
        truth  = TT_OR;
        exp_fv = 4'd0;
        exp_fc = 0;
        // reference: each vector whose gate output differs from the table fails
        for (int v = 0; v < 4; v++) begin
            if (tt[v] != truth[v]) begin
                exp_fv[v] = 1'b1;
                exp_fc    = exp_fc + 1;
            end
        end
        gate_tt     = tt;
        strict_mode = strict;
        for (int k = 0; k < 3; k++) lat[k] = -1;

        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("accept_busy%0d", k), 8'(busy_w[k]), 8'd1);
            check($sformatf("accept_done%0d", k), 8'(done_w[k]), 8'd0);
            check($sformatf("accept_pass%0d", k), 8'(pass_w[k]), 8'd0);
            check($sformatf("accept_fv%0d", k), 8'(fv_w[k]), 8'd0);
            check($sformatf("accept_fc%0d", k), 8'(fc_w[k]), 8'd0);
        end

        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(posedge clk);
            #1;
            if (repulse && cyc == 5) start = 1'b1;
            if (cyc == 6) start = 1'b0;
            for (int k = 0; k < 3; k++) begin
                for (int j = 0; j < 4; j++) begin
                    if (cyc == 1 + j * (settle_of(k) + 2)) begin
                        check($sformatf("ab%0d_v%0d", k, j),
                              8'({b_w[k], a_w[k]}), 8'(j));
                    end
                end
                if (done_w[k] === 1'b1 && lat[k] < 0) lat[k] = cyc;
            end
        end

        for (int k = 0; k < 3; k++) begin
            check($sformatf("latency%0d", k), 8'(lat[k]), 8'(4 * (settle_of(k) + 2)));
            check($sformatf("done%0d", k), 8'(done_w[k]), 8'd1);
            check($sformatf("busy%0d", k), 8'(busy_w[k]), 8'd0);
            check($sformatf("pass%0d", k), 8'(pass_w[k]), 8'(exp_fc == 0));
            check($sformatf("fail_vec%0d", k), 8'(fv_w[k]), 8'(exp_fv));
            check($sformatf("fail_count%0d", k), 8'(fc_w[k]), 8'(exp_fc));
            check($sformatf("hold_ab%0d", k), 8'({b_w[k], a_w[k]}), 8'd3);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        gate_tt     = TT_OR;
        strict_mode = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("idle");

        // directed gates against the OR table
        run_test(TT_OR,   1'b1, 1'b0);
        run_test(TT_AND,  1'b1, 1'b0);
        run_test(4'b1111, 1'b1, 1'b0);
        run_test(4'b0000, 1'b1, 1'b0);
        run_test(TT_OR,   1'b1, 1'b1);
        run_test(TT_XNOR, 1'b1, 1'b0);
        run_test(TT_NOR,  1'b1, 1'b1);
        run_test(TT_XOR,  1'b0, 1'b0);

        // random gates, sampling-time checking and restart pulses
        for (int i = 0; i < 10; i++) begin
            run_test(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)));
        end

        // reset while the S=2 instance is settling vector 2
        gate_tt     = TT_OR;
        strict_mode = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("midrun_ab0", 8'({b_w[0], a_w[0]}), 8'd2);
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrun_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_reset_vals("after_reset");
        run_test(TT_OR, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
